// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - mode/state encodings and start-value helpers for the LED pattern sequencer
package led_pkg;

  localparam int MAX_WIDTH = 64;

  typedef enum logic [1:0] {
    MODE_FILL_DRAIN = 2'd0,
    MODE_CHASE      = 2'd1,
    MODE_BOUNCE     = 2'd2,
    MODE_BLINK      = 2'd3
  } led_mode_e;

  typedef enum logic [2:0] {
    ST_FILL,
    ST_DRAIN,
    ST_CHASE,
    ST_BOUNCE_L,
    ST_BOUNCE_R,
    ST_BLINK
  } led_state_e;

  function automatic logic [MAX_WIDTH-1:0] start_val(led_mode_e mode, int width);
    start_val = '0;
    if (width >= 1 && (mode == MODE_CHASE || mode == MODE_BOUNCE))
      start_val[0] = 1'b1;
  endfunction

  function automatic led_state_e start_state(led_mode_e mode);
    case (mode)
      MODE_CHASE:  start_state = ST_CHASE;
      MODE_BOUNCE: start_state = ST_BOUNCE_L;
      MODE_BLINK:  start_state = ST_BLINK;
      default:     start_state = ST_FILL;
    endcase
  endfunction

endpackage

// File: rtl/led_tick_divider.sv
// rtl/led_tick_divider.sv - enable-gated prescaler, TICK on the DIV-th enabled cycle
module led_tick_divider #(
  parameter int DIV = 50_000_000
) (
  input  logic CLK,
  input  logic RST,
  input  logic EN,
  output logic TICK
);

  localparam int DIV_W = $clog2(DIV + 1);
  localparam logic [DIV_W-1:0] LAST = DIV_W'(DIV - 1);

  logic [DIV_W-1:0] count;

  always_ff @(posedge CLK) begin
    if (RST) begin
      count <= '0;
    end else if (EN) begin
      if (count == LAST)
        count <= '0;
      else
        count <= count + DIV_W'(1);
    end
  end

  assign TICK = EN && (count == LAST);

endmodule

// File: rtl/led_pattern_sequencer.sv
// rtl/led_pattern_sequencer.sv - four-mode LED bar sequencer with period-aligned mode switching
module led_pattern_sequencer
  import led_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV   = 50_000_000
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             MODE_REQ,
  input  logic [1:0]       MODE_SEL,
  output logic             MODE_ACK,
  output logic [1:0]       MODE,
  output logic             STEP,
  output logic             CYC_DONE,
  output logic [WIDTH-1:0] Q
);

  logic tick;

  led_tick_divider #(.DIV(DIV)) u_div (
    .CLK  (CLK),
    .RST  (RST),
    .EN   (EN),
    .TICK (tick)
  );

  led_state_e       state, state_nxt;
  led_mode_e        mode_r, mode_nxt;
  led_mode_e        pend_sel, pend_sel_nxt;
  logic             pending, pending_nxt;
  logic             at_start, at_start_nxt;
  logic [WIDTH-1:0] q_nxt, q_start;
  logic             step_nxt, done_nxt, ack_nxt, boundary;

  assign q_start = WIDTH'(start_val(pend_sel, WIDTH));
  assign MODE    = mode_r;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= ST_FILL;
      mode_r   <= MODE_FILL_DRAIN;
      pend_sel <= MODE_FILL_DRAIN;
      pending  <= 1'b0;
      at_start <= 1'b1;
      Q        <= '0;
      STEP     <= 1'b0;
      CYC_DONE <= 1'b0;
      MODE_ACK <= 1'b0;
    end else begin
      state    <= state_nxt;
      mode_r   <= mode_nxt;
      pend_sel <= pend_sel_nxt;
      pending  <= pending_nxt;
      at_start <= at_start_nxt;
      Q        <= q_nxt;
      STEP     <= step_nxt;
      CYC_DONE <= done_nxt;
      MODE_ACK <= ack_nxt;
    end
  end

  // at_start marks that the previous period finished; a pending mode only takes over on the tick that would begin the next one
  always_comb begin
    state_nxt    = state;
    mode_nxt     = mode_r;
    pend_sel_nxt = pend_sel;
    pending_nxt  = pending;
    at_start_nxt = at_start;
    q_nxt        = Q;
    step_nxt     = 1'b0;
    done_nxt     = 1'b0;
    ack_nxt      = 1'b0;
    boundary     = 1'b0;

    if (tick) begin
      step_nxt = 1'b1;
      if (pending && at_start) begin
        mode_nxt     = pend_sel;
        state_nxt    = start_state(pend_sel);
        q_nxt        = q_start;
        pending_nxt  = 1'b0;
        ack_nxt      = 1'b1;
        at_start_nxt = 1'b0;
      end else begin
        case (state)
          ST_FILL: begin
            q_nxt = {Q[WIDTH-2:0], 1'b1};
            if (&q_nxt) state_nxt = ST_DRAIN;
          end
          ST_DRAIN: begin
            q_nxt = {1'b0, Q[WIDTH-1:1]};
            if (q_nxt == '0) begin
              state_nxt = ST_FILL;
              boundary  = 1'b1;
            end
          end
          ST_CHASE: begin
            q_nxt    = {Q[WIDTH-2:0], Q[WIDTH-1]};
            boundary = Q[WIDTH-1];
          end
          ST_BOUNCE_L: begin
            q_nxt = {Q[WIDTH-2:0], 1'b0};
            if (q_nxt[WIDTH-1]) state_nxt = ST_BOUNCE_R;
          end
          ST_BOUNCE_R: begin
            q_nxt = {1'b0, Q[WIDTH-1:1]};
            if (q_nxt[0]) begin
              state_nxt = ST_BOUNCE_L;
              boundary  = 1'b1;
            end
          end
          ST_BLINK: begin
            q_nxt    = ~Q;
            boundary = (q_nxt == '0);
          end
          default: begin
            state_nxt = ST_FILL;
            q_nxt     = '0;
          end
        endcase
        done_nxt     = boundary;
        at_start_nxt = boundary;
      end
    end

    // a request landing on the applying tick is registered after the apply, so it waits a full period
    if (MODE_REQ) begin
      pending_nxt  = 1'b1;
      pend_sel_nxt = led_mode_e'(MODE_SEL);
    end
  end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// tb/tb_led_pattern_sequencer.sv - randomized bench against a period/index reference model
module tb_led_pattern_sequencer;

  localparam int W = 8;
  localparam int D = 4;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         EN = 1'b0;
  logic         MODE_REQ = 1'b0;
  logic [1:0]   MODE_SEL = 2'd0;
  logic         MODE_ACK, STEP, CYC_DONE;
  logic [1:0]   MODE;
  logic [W-1:0] Q;

  int errors = 0;
  int checks = 0;

  int           m_mode, m_idx, m_cnt, m_psel;
  bit           m_pend, m_at_start, m_step, m_done, m_ack;
  logic [W-1:0] m_q;

  led_pattern_sequencer #(.WIDTH(W), .DIV(D)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .EN       (EN),
    .MODE_REQ (MODE_REQ),
    .MODE_SEL (MODE_SEL),
    .MODE_ACK (MODE_ACK),
    .MODE     (MODE),
    .STEP     (STEP),
    .CYC_DONE (CYC_DONE),
    .Q        (Q)
  );

  always #5 CLK = ~CLK;

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic int period(input int mode);
    case (mode)
      0:       return 2 * W;
      1:       return W;
      2:       return 2 * W - 2;
      default: return 2;
    endcase
  endfunction

  // LED image idx steps into a period of the given mode
  function automatic logic [W-1:0] pattern(input int mode, input int idx);
    int v;
    case (mode)
      0:       v = (idx <= W) ? (1 << idx) - 1 : (1 << (2 * W - idx)) - 1;
      1:       v = 1 << (idx % W);
      2:       v = (idx < W) ? (1 << idx) : (1 << (2 * W - 2 - idx));
      default: v = (idx % 2 == 1) ? 32'hFFFF_FFFF : 0;
    endcase
    return W'(v);
  endfunction

  task automatic model_clock(input bit rst, input bit en, input bit req, input int sel);
    bit tick;
    if (rst) begin
      m_mode = 0; m_idx = 0; m_cnt = 0; m_psel = 0;
      m_pend = 0; m_at_start = 1;
      m_step = 0; m_done = 0; m_ack = 0;
      m_q = '0;
      return;
    end
    m_step = 0; m_done = 0; m_ack = 0;
    tick = 0;
    if (en) begin
      m_cnt++;
      if (m_cnt == D) begin
        tick = 1;
        m_cnt = 0;
      end
    end
    if (tick) begin
      m_step = 1;
      if (m_pend && m_at_start) begin
        m_mode = m_psel;
        m_idx = 0;
        m_pend = 0;
        m_ack = 1;
        m_at_start = 0;
      end else begin
        m_idx = (m_idx + 1) % period(m_mode);
        m_done = (m_idx == 0);
        m_at_start = m_done;
      end
      m_q = pattern(m_mode, m_idx);
    end
    if (req) begin
      m_pend = 1;
      m_psel = sel;
    end
  endtask

  task automatic drive_cycle(input bit rst, input bit en, input bit req, input logic [1:0] sel);
    RST = rst;
    EN = en;
    MODE_REQ = req;
    MODE_SEL = sel;
    @(posedge CLK);
    model_clock(rst, en, req, int'(sel));
    @(negedge CLK);
    expect_eq("Q", 32'(Q), 32'(m_q));
    expect_eq("MODE", 32'(MODE), 32'(m_mode));
    expect_eq("STEP", 32'(STEP), 32'(m_step));
    expect_eq("CYC_DONE", 32'(CYC_DONE), 32'(m_done));
    expect_eq("MODE_ACK", 32'(MODE_ACK), 32'(m_ack));
  endtask

  initial begin
    @(negedge CLK);
    drive_cycle(1'b1, 1'b1, 1'b1, 2'd2);
    drive_cycle(1'b1, 1'b0, 1'b0, 2'd0);
    for (int i = 0; i < 70; i++)
      drive_cycle(1'b0, 1'b1, 1'b0, 2'd0);
    for (int i = 0; i < 5000; i++) begin
      drive_cycle($urandom_range(0, 399) == 0,
                  $urandom_range(0, 99) < 85,
                  $urandom_range(0, 29) == 0,
                  2'($urandom_range(0, 3)));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
